// File: rtl/switching_activity_pkg.sv
// Shared types and helpers for the switching-activity monitor.
//   state_e : monitor FSM states
//   sat_add : saturating add clamped to a runtime width, returns {overflow, value}
//   DEF_*   : default widths
package switching_activity_pkg;

  localparam int unsigned DEF_N_IN  = 4;
  localparam int unsigned DEF_N_OUT = 1;
  localparam int unsigned DEF_WIN_W = 16;
  localparam int unsigned DEF_CNT_W = 20;

  // Fixed working width of sat_add; accumulator widths up to SAT_W-1 are supported.
  localparam int unsigned SAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Adds in SAT_W+1 bits, then clamps to 2^w-1; MSB of the result flags the clamp.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                             input logic [SAT_W-1:0] inc,
                                             input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    if (sum > lim) begin
      sat_add = {1'b1, lim[SAT_W-1:0]};
    end else begin
      sat_add = {1'b0, sum[SAT_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/switching_activity_monitor_act_hamming.sv
// Combinational Hamming distance between two W-bit vectors.
//   a, b   : vectors to compare
//   dist_c : popcount(a ^ b), $clog2(W+1) bits
module act_hamming #(
  parameter  int unsigned W  = 4,
  localparam int unsigned DW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [DW-1:0] dist_c
);

  logic [W-1:0] diff_c;

  assign diff_c = a ^ b;

  // Bit-serial popcount; small W keeps this a shallow adder tree after synthesis.
  always_comb begin
    dist_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      dist_c = dist_c + DW'(diff_c[i]);
    end
  end

endmodule

// File: rtl/switching_activity_monitor.sv
// Switching-activity monitor: counts input/output bit toggles between consecutive
// valid samples over a programmed number of transitions and reports the totals
// through a valid/ready handshake.
// Optional macro SWITCHING_ACTIVITY_PEAK_EN adds peak_out_toggles (max per-sample
// output Hamming distance in the window).
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   start, window_len         : begin a window; length latched on accepted start (0 -> 1)
//   sample_valid, in_bits,
//   out_bits                  : sampled sub-circuit vector
//   busy                      : not IDLE
//   rpt_valid, rpt_ready      : report handshake
//   in_toggles, out_toggles   : saturating toggle accumulators
//   sat                       : an accumulator clamped this window
//   peak_out_toggles          : (macro only) peak output distance
module switching_activity_monitor
  import switching_activity_pkg::*;
#(
  parameter  int unsigned N_IN   = DEF_N_IN,
  parameter  int unsigned N_OUT  = DEF_N_OUT,
  parameter  int unsigned WIN_W  = DEF_WIN_W,
  parameter  int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned IN_DW  = $clog2(N_IN + 1),
  localparam int unsigned OUT_DW = $clog2(N_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIN_W-1:0]  window_len,
  input  logic              sample_valid,
  input  logic [N_IN-1:0]   in_bits,
  input  logic [N_OUT-1:0]  out_bits,
  output logic              busy,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  in_toggles,
  output logic [CNT_W-1:0]  out_toggles,
`ifdef SWITCHING_ACTIVITY_PEAK_EN
  output logic [OUT_DW-1:0] peak_out_toggles,
`endif
  output logic              sat
);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_len_q, win_len_d;
  logic [WIN_W-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0]    base_in_q, base_in_d;
  logic [N_OUT-1:0]   base_out_q, base_out_d;
  logic [CNT_W-1:0]   in_tog_q, in_tog_d;
  logic [CNT_W-1:0]   out_tog_q, out_tog_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic [OUT_DW-1:0]  peak_q, peak_d;

  logic [IN_DW-1:0]   in_dist_c;
  logic [OUT_DW-1:0]  out_dist_c;
  logic [SAT_W:0]     in_sum_c;
  logic [SAT_W:0]     out_sum_c;
  logic               unused_sum_hi_c;

  act_hamming #(.W(N_IN)) u_in_ham (
    .a      (in_bits),
    .b      (base_in_q),
    .dist_c (in_dist_c)
  );

  act_hamming #(.W(N_OUT)) u_out_ham (
    .a      (out_bits),
    .b      (base_out_q),
    .dist_c (out_dist_c)
  );

  assign in_sum_c  = sat_add(SAT_W'(in_tog_q),  SAT_W'(in_dist_c),  CNT_W);
  assign out_sum_c = sat_add(SAT_W'(out_tog_q), SAT_W'(out_dist_c), CNT_W);

  // Clamped value always fits CNT_W; upper working bits are structurally zero.
  assign unused_sum_hi_c = ^{in_sum_c[SAT_W-1:CNT_W], out_sum_c[SAT_W-1:CNT_W]};

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    cnt_d      = cnt_q;
    base_in_d  = base_in_q;
    base_out_d = base_out_q;
    in_tog_d   = in_tog_q;
    out_tog_d  = out_tog_q;
    sat_d      = sat_q;
    peak_d     = peak_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_len_d = (window_len == '0) ? WIN_W'(1) : window_len;
          cnt_d     = '0;
          in_tog_d  = '0;
          out_tog_d = '0;
          sat_d     = 1'b0;
          peak_d    = '0;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        // First valid sample only establishes the baseline.
        if (sample_valid) begin
          base_in_d  = in_bits;
          base_out_d = out_bits;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (sample_valid) begin
          base_in_d  = in_bits;
          base_out_d = out_bits;
          in_tog_d   = in_sum_c[CNT_W-1:0];
          out_tog_d  = out_sum_c[CNT_W-1:0];
          sat_d      = sat_q | in_sum_c[SAT_W] | out_sum_c[SAT_W];
          if (out_dist_c > peak_q) begin
            peak_d = out_dist_c;
          end
          cnt_d = cnt_q + WIN_W'(1);
          if (cnt_d == win_len_q) begin
            state_d = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        if (rpt_valid_q && rpt_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    rpt_valid_d = (state_d == ST_REPORT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_len_q   <= '0;
      cnt_q       <= '0;
      base_in_q   <= '0;
      base_out_q  <= '0;
      in_tog_q    <= '0;
      out_tog_q   <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      rpt_valid_q <= 1'b0;
      peak_q      <= '0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      cnt_q       <= cnt_d;
      base_in_q   <= base_in_d;
      base_out_q  <= base_out_d;
      in_tog_q    <= in_tog_d;
      out_tog_q   <= out_tog_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
      rpt_valid_q <= rpt_valid_d;
      peak_q      <= peak_d;
    end
  end

  assign busy        = busy_q;
  assign rpt_valid   = rpt_valid_q;
  assign in_toggles  = in_tog_q;
  assign out_toggles = out_tog_q;
  assign sat         = sat_q;

`ifdef SWITCHING_ACTIVITY_PEAK_EN
  assign peak_out_toggles = peak_q;
`else
  logic unused_peak_c;
  assign unused_peak_c = ^peak_q;
`endif

endmodule

// File: tb/tb_switching_activity_monitor.sv
// Scoreboard bench for switching_activity_monitor: stimulus tasks compute the
// expected report from the toggle-counting rules and queue it; a monitor pops
// and compares on every report handshake.
module tb_switching_activity_monitor;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_OUT = 2;
  localparam int unsigned WIN_W = 16;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIN_W-1:0]  window_len;
  logic              sample_valid;
  logic [N_IN-1:0]   in_bits;
  logic [N_OUT-1:0]  out_bits;
  logic              busy;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [CNT_W-1:0]  in_toggles;
  logic [CNT_W-1:0]  out_toggles;
  logic              sat;
`ifdef SWITCHING_ACTIVITY_PEAK_EN
  logic [$clog2(N_OUT+1)-1:0] peak_out_toggles;
`endif

  switching_activity_monitor #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WIN_W(WIN_W), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .window_len   (window_len),
    .sample_valid (sample_valid),
    .in_bits      (in_bits),
    .out_bits     (out_bits),
    .busy         (busy),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .in_toggles   (in_toggles),
    .out_toggles  (out_toggles),
`ifdef SWITCHING_ACTIVITY_PEAK_EN
    .peak_out_toggles (peak_out_toggles),
`endif
    .sat          (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned in_t;
    int unsigned out_t;
    bit          sat;
    int unsigned peak;
  } rpt_t;

  rpt_t             exp_q[$];
  logic [N_IN-1:0]  d_in[$];
  logic [N_OUT-1:0] d_out[$];
  int               checks   = 0;
  int               failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on handshake, check stability while stalled.
  bit               held;
  logic [CNT_W-1:0] h_in, h_out;
  logic             h_sat;
  always @(negedge clk) begin
    rpt_t cur;
    if (rst_n && rpt_valid) begin
      if (held) begin
        check("hold_in_toggles",  64'(in_toggles),  64'(h_in));
        check("hold_out_toggles", 64'(out_toggles), 64'(h_out));
        check("hold_sat",         64'(sat),         64'(h_sat));
      end
      if (rpt_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_report", 64'(rpt_valid), 64'(0));
        end else begin
          cur = exp_q.pop_front();
          check("in_toggles",  64'(in_toggles),  64'(cur.in_t));
          check("out_toggles", 64'(out_toggles), 64'(cur.out_t));
          check("sat",         64'(sat),         64'(cur.sat));
`ifdef SWITCHING_ACTIVITY_PEAK_EN
          check("peak_out_toggles", 64'(peak_out_toggles), 64'(cur.peak));
`endif
        end
      end else begin
        held  = 1'b1;
        h_in  = in_toggles;
        h_out = out_toggles;
        h_sat = sat;
      end
    end else begin
      held = 1'b0;
    end
  end

  // One full window: start, baseline + eff_len counted samples, report, handshake.
  task automatic run_window(input int len, input int gap_max, input int bp,
                            input bit poke_start, input bit poke_rpt);
    int unsigned     eff;
    int unsigned     n_samp;
    int unsigned     d;
    rpt_t            e;
    logic [N_IN-1:0]  si, pin;
    logic [N_OUT-1:0] so, pout;
    eff    = (len == 0) ? 1 : len;
    n_samp = eff + 1;
    e      = '{0, 0, 1'b0, 0};
    pin    = '0;
    pout   = '0;

    start = 1'b1; window_len = WIN_W'(len);
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));

    for (int k = 0; k < int'(n_samp); k++) begin
      repeat ((gap_max > 0) ? $urandom_range(gap_max, 0) : 0) begin
        sample_valid = 1'b0;
        in_bits  = N_IN'($urandom);
        out_bits = N_OUT'($urandom);
        tick();
      end
      if (d_in.size() > 0) begin
        si = d_in.pop_front();
        so = d_out.pop_front();
      end else begin
        si = N_IN'($urandom);
        so = N_OUT'($urandom);
      end
      if (k > 0) begin
        d = $countones(si ^ pin);
        e.in_t += d;
        if (e.in_t > CMAX) begin e.in_t = CMAX; e.sat = 1'b1; end
        d = $countones(so ^ pout);
        e.out_t += d;
        if (e.out_t > CMAX) begin e.out_t = CMAX; e.sat = 1'b1; end
        if (d > e.peak) e.peak = d;
      end
      pin  = si;
      pout = so;
      sample_valid = 1'b1;
      in_bits      = si;
      out_bits     = so;
      start        = poke_start && (k == 2);
      window_len   = WIN_W'(1);
      if (k == int'(n_samp) - 1) exp_q.push_back(e);
      tick();
      start = 1'b0;
    end
    sample_valid = 1'b0;
    check("rpt_valid_latency", 64'(rpt_valid), 64'(1));

    for (int b = 0; b < bp; b++) begin
      if (poke_rpt) begin
        sample_valid = 1'b1;
        in_bits  = N_IN'($urandom);
        out_bits = N_OUT'($urandom);
      end
      tick();
      check("rpt_valid_held", 64'(rpt_valid), 64'(1));
    end

    rpt_ready = 1'b1; start = 1'b1; window_len = WIN_W'($urandom);
    sample_valid = 1'b0;
    tick();
    rpt_ready = 1'b0; start = 1'b0;
    check("rpt_valid_drop", 64'(rpt_valid), 64'(0));
    check("idle_after_hs",  64'(busy),      64'(0));
    tick();
    check("start_at_hs_ignored", 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; window_len = '0; sample_valid = 1'b0;
    in_bits = '0; out_bits = '0; rpt_ready = 1'b0;
    held = 1'b0;
    #12;
    check("reset_busy",        64'(busy),        64'(0));
    check("reset_rpt_valid",   64'(rpt_valid),   64'(0));
    check("reset_in_toggles",  64'(in_toggles),  64'(0));
    check("reset_out_toggles", 64'(out_toggles), 64'(0));
    check("reset_sat",         64'(sat),         64'(0));
    rst_n = 1'b1;
    tick();

    // Basic window: expect in=6, out=2.
    d_in  = '{4'b0000, 4'b1111, 4'b1110, 4'b0110};
    d_out = '{2'b00,   2'b01,   2'b01,   2'b00};
    run_window(3, 0, 0, 1'b0, 1'b0);

    // Same samples with bubbles, 5-cycle backpressure, samples during REPORT.
    d_in  = '{4'b0000, 4'b1111, 4'b1110, 4'b0110};
    d_out = '{2'b00,   2'b01,   2'b01,   2'b00};
    run_window(3, 3, 5, 1'b0, 1'b1);

    // Saturation: 20 transitions of 4 toggles exceed 2^CNT_W-1.
    for (int i = 0; i < 21; i++) begin
      d_in.push_back((i % 2 == 0) ? 4'b0000 : 4'b1111);
      d_out.push_back((i % 2 == 0) ? 2'b00 : 2'b11);
    end
    run_window(20, 0, 1, 1'b0, 1'b0);

    // Window length 0 behaves as 1.
    d_in  = '{4'b0001, 4'b0011};
    d_out = '{2'b00,   2'b01};
    run_window(0, 1, 0, 1'b0, 1'b0);

    // start during COUNT is ignored.
    run_window(6, 1, 2, 1'b1, 1'b0);

    // Output peak pattern 00,11,10,01: out=5, peak=2.
    d_in  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    d_out = '{2'b00,   2'b11,   2'b10,   2'b01};
    run_window(3, 0, 0, 1'b0, 1'b0);

    // Reset after two counted samples aborts the window.
    start = 1'b1; window_len = WIN_W'(5);
    tick();
    start = 1'b0;
    repeat (3) begin
      sample_valid = 1'b1;
      in_bits  = N_IN'($urandom);
      out_bits = N_OUT'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_busy",        64'(busy),        64'(0));
    check("midrst_rpt_valid",   64'(rpt_valid),   64'(0));
    check("midrst_in_toggles",  64'(in_toggles),  64'(0));
    check("midrst_out_toggles", 64'(out_toggles), 64'(0));
    check("midrst_sat",         64'(sat),         64'(0));
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1;
      in_bits  = N_IN'($urandom);
      out_bits = N_OUT'($urandom);
      rpt_ready = 1'b1;
      tick();
      check("no_report_after_reset", 64'(rpt_valid), 64'(0));
    end
    rpt_ready = 1'b0; sample_valid = 1'b0;

    // Randomized windows.
    for (int w = 0; w < 25; w++) begin
      run_window(int'($urandom_range(12, 0)), int'($urandom_range(2, 0)),
                 int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)));
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
